position_overlay: RTL and testbench

Draws a tracking marker on the outgoing video stream from the per-frame object centre produced by the position-measurement stage. Sits after `measure_position` in the VGA pipeline and uses the same `vga_x`/`vga_y` raster counters. Once per frame it samples the measured `(x,y)` centre and applies a first-order smoothing filter. A frame-counting track/hold/idle state machine decides whether a marker is drawn. The marker is a square outline, overlaid onto the pixel stream with fixed pipeline latency.

---
 rtl/position_overlay.sv | 173 +++++++++++++++++
 tb/tb_position_overlay.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/position_overlay.sv
// Tracking-marker overlay: smooths the per-frame object centre and draws a square
// outline around it on the pixel stream, two cycles behind the raster inputs.
//
//   state    | meaning
//   ST_IDLE  | no target, no marker drawn
//   ST_TRACK | target seen last frame, marker drawn at filtered centre
//   ST_HOLD  | target missed for miss_cnt frames, marker held at last centre
module position_overlay #(
    parameter int INPUT_WIDTH  = 11,
    parameter int COLOR_WIDTH  = 10,
    parameter int FRAME_X_MAX  = 640,
    parameter int FRAME_Y_MAX  = 480,
    parameter int BOX_HALF     = 16,
    parameter int HOLD_FRAMES  = 8,
    parameter int SMOOTH_SHIFT = 2,
    parameter logic [3*COLOR_WIDTH-1:0] MARKER_COLOR = {10'h3FF, 10'h000, 10'h000}
) (
    input  logic                       clk,
    input  logic                       aresetn,
    input  logic                       enable,
    input  logic [INPUT_WIDTH-1:0]     vga_x,
    input  logic [INPUT_WIDTH-1:0]     vga_y,
    input  logic [3*COLOR_WIDTH-1:0]   pixel_in,
    input  logic [INPUT_WIDTH-1:0]     x_position,
    input  logic [INPUT_WIDTH-1:0]     y_position,
    output logic [INPUT_WIDTH-1:0]     vga_x_out,
    output logic [INPUT_WIDTH-1:0]     vga_y_out,
    output logic [3*COLOR_WIDTH-1:0]   pixel_out,
    output logic                       marker_valid
);
    localparam int CW = INPUT_WIDTH + 1;
    localparam int DW = INPUT_WIDTH + 2;
    localparam int PW = 3 * COLOR_WIDTH;

    typedef enum logic [1:0] {ST_IDLE, ST_TRACK, ST_HOLD} state_t;

    state_t                  state_q, state_d;
    logic                    eof_d_q, eof_d_d;
    logic [7:0]              miss_cnt_q, miss_cnt_d;
    logic signed [CW-1:0]    cx_q, cx_d, cy_q, cy_d;
    logic signed [CW-1:0]    dx0_q, dx0_d, dy0_q, dy0_d;
    logic                    upd_q, upd_d;
    logic                    hit1_q, hit1_d;
    logic [INPUT_WIDTH-1:0]  x1_q, x1_d, y1_q, y1_d, x2_q, x2_d, y2_q, y2_d;
    logic [PW-1:0]           pix1_q, pix1_d, pix2_q, pix2_d;

    logic                    detect;
    logic signed [CW-1:0]    raw_x, raw_y, filt_x, filt_y;
    logic signed [DW-1:0]    diff_x, diff_y, step_x, step_y;
    logic [DW-1:0]           ex, ey, ax, ay;

    always_comb begin
        eof_d_d = (vga_x == INPUT_WIDTH'(FRAME_X_MAX)) && (vga_y == INPUT_WIDTH'(FRAME_Y_MAX));
        detect  = (x_position != '0) || (y_position != '0);
        raw_x   = {1'b0, x_position};
        raw_y   = {1'b0, y_position};
        diff_x  = {raw_x[CW-1], raw_x} - {cx_q[CW-1], cx_q};
        diff_y  = {raw_y[CW-1], raw_y} - {cy_q[CW-1], cy_q};
        step_x  = diff_x >>> SMOOTH_SHIFT;
        step_y  = diff_y >>> SMOOTH_SHIFT;
        filt_x  = cx_q + step_x[CW-1:0];
        filt_y  = cy_q + step_y[CW-1:0];

        state_d    = state_q;
        miss_cnt_d = miss_cnt_q;
        cx_d       = cx_q;
        cy_d       = cy_q;
        upd_d      = 1'b0;
        if (!enable) begin
            state_d    = ST_IDLE;
            miss_cnt_d = '0;
            cx_d       = '0;
            cy_d       = '0;
        end else if (eof_d_q) begin
            case (state_q)
                ST_IDLE: begin
                    if (detect) begin
                        cx_d    = raw_x;
                        cy_d    = raw_y;
                        upd_d   = 1'b1;
                        state_d = ST_TRACK;
                    end
                end
                ST_TRACK: begin
                    if (detect) begin
                        cx_d  = filt_x;
                        cy_d  = filt_y;
                        upd_d = 1'b1;
                    end else if (HOLD_FRAMES == 1) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d    = ST_HOLD;
                        miss_cnt_d = 8'd1;
                    end
                end
                ST_HOLD: begin
                    if (detect) begin
                        cx_d       = filt_x;
                        cy_d       = filt_y;
                        upd_d      = 1'b1;
                        miss_cnt_d = '0;
                        state_d    = ST_TRACK;
                    end else if (miss_cnt_q + 8'd1 == 8'(HOLD_FRAMES)) begin
                        miss_cnt_d = '0;
                        state_d    = ST_IDLE;
                    end else begin
                        miss_cnt_d = miss_cnt_q + 8'd1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // draw centre only moves right after an update, so it is frozen for the frame
        dx0_d = upd_q ? cx_q : dx0_q;
        dy0_d = upd_q ? cy_q : dy0_q;

        ex = {2'b00, vga_x} - {dx0_q[CW-1], dx0_q};
        ey = {2'b00, vga_y} - {dy0_q[CW-1], dy0_q};
        ax = ex[DW-1] ? (~ex + DW'(1)) : ex;
        ay = ey[DW-1] ? (~ey + DW'(1)) : ey;
        hit1_d = enable && (state_q != ST_IDLE)
                 && (ax <= DW'(BOX_HALF)) && (ay <= DW'(BOX_HALF))
                 && ((ax == DW'(BOX_HALF)) || (ay == DW'(BOX_HALF)));
        x1_d   = vga_x;
        y1_d   = vga_y;
        pix1_d = pixel_in;
        x2_d   = x1_q;
        y2_d   = y1_q;
        pix2_d = hit1_q ? MARKER_COLOR : pix1_q;
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= ST_IDLE;
            eof_d_q    <= 1'b0;
            miss_cnt_q <= '0;
            cx_q       <= '0;
            cy_q       <= '0;
            dx0_q      <= '0;
            dy0_q      <= '0;
            upd_q      <= 1'b0;
            hit1_q     <= 1'b0;
            x1_q       <= '0;
            y1_q       <= '0;
            pix1_q     <= '0;
            x2_q       <= '0;
            y2_q       <= '0;
            pix2_q     <= '0;
        end else begin
            state_q    <= state_d;
            eof_d_q    <= eof_d_d;
            miss_cnt_q <= miss_cnt_d;
            cx_q       <= cx_d;
            cy_q       <= cy_d;
            dx0_q      <= dx0_d;
            dy0_q      <= dy0_d;
            upd_q      <= upd_d;
            hit1_q     <= hit1_d;
            x1_q       <= x1_d;
            y1_q       <= y1_d;
            pix1_q     <= pix1_d;
            x2_q       <= x2_d;
            y2_q       <= y2_d;
            pix2_q     <= pix2_d;
        end
    end

    assign vga_x_out    = x2_q;
    assign vga_y_out    = y2_q;
    assign pixel_out    = pix2_q;
    assign marker_valid = (state_q == ST_TRACK) || (state_q == ST_HOLD);
endmodule

// File: tb/tb_position_overlay.sv
// Randomized bench for position_overlay against a frame-level reference model of
// the track/hold/idle behaviour, smoothing filter and square-outline marker.
module tb_position_overlay;
    localparam int W  = 11;
    localparam int PW = 30;
    localparam int HB = 16;
    localparam int HF = 8;
    localparam int S  = 2;
    localparam logic [PW-1:0] RED = {10'h3FF, 10'h000, 10'h000};

    logic          clk, aresetn, enable;
    logic [W-1:0]  vga_x, vga_y, x_position, y_position, vga_x_out, vga_y_out;
    logic [PW-1:0] pixel_in, pixel_out;
    logic          marker_valid;

    position_overlay #(
        .INPUT_WIDTH(W), .COLOR_WIDTH(10), .FRAME_X_MAX(640), .FRAME_Y_MAX(480),
        .BOX_HALF(HB), .HOLD_FRAMES(HF), .SMOOTH_SHIFT(S), .MARKER_COLOR(RED)
    ) dut (
        .clk(clk), .aresetn(aresetn), .enable(enable),
        .vga_x(vga_x), .vga_y(vga_y), .pixel_in(pixel_in),
        .x_position(x_position), .y_position(y_position),
        .vga_x_out(vga_x_out), .vga_y_out(vga_y_out),
        .pixel_out(pixel_out), .marker_valid(marker_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // reference model: 0 idle, 1 track, 2 hold
    int m_state = 0, m_miss = 0, m_cx = 0, m_cy = 0, m_dx = 0, m_dy = 0;
    bit m_en = 1'b1;
    bit m_upd = 1'b0;

    function automatic int smooth(input int c, input int raw);
        int d, div;
        d   = raw - c;
        div = 1 << S;
        if (d >= 0) return c + d / div;
        return c - ((-d + div - 1) / div);
    endfunction

    function automatic bit m_hit(input int px, input int py);
        int ax, ay;
        if (!m_en || m_state == 0) return 1'b0;
        ax = (px > m_dx) ? px - m_dx : m_dx - px;
        ay = (py > m_dy) ? py - m_dy : m_dy - py;
        return (ax <= HB) && (ay <= HB) && (ax == HB || ay == HB);
    endfunction

    task automatic m_frame_end(input int px, input int py);
        bit det;
        det   = (px != 0) || (py != 0);
        m_upd = 1'b0;
        if (m_state == 0) begin
            if (det) begin m_cx = px; m_cy = py; m_state = 1; m_upd = 1'b1; end
        end else if (det) begin
            m_cx = smooth(m_cx, px); m_cy = smooth(m_cy, py);
            m_state = 1; m_miss = 0; m_upd = 1'b1;
        end else begin
            m_miss++;
            if (m_miss == HF) begin m_state = 0; m_miss = 0; end
            else m_state = 2;
        end
    endtask

    task automatic m_clear();
        m_state = 0; m_miss = 0; m_cx = 0; m_cy = 0;
    endtask

    bit           p_valid = 1'b0, p_chk = 1'b0;
    logic [W-1:0] p_x, p_y;
    logic [PW-1:0] p_exp;

    // drive one pixel; checks the outputs belonging to the previous pixel (2-cycle latency)
    task automatic drive(input int x, input int y, input bit chk);
        logic [PW-1:0] pix, cur;
        pix = PW'($urandom);
        vga_x = W'(x); vga_y = W'(y); pixel_in = pix;
        cur = m_hit(x, y) ? RED : pix;
        @(posedge clk); #1;
        if (p_valid) begin
            check("x_out", 32'(vga_x_out), 32'(p_x));
            check("y_out", 32'(vga_y_out), 32'(p_y));
            if (p_chk) check($sformatf("pix(%0d,%0d)", p_x, p_y), 32'(pixel_out), 32'(p_exp));
        end
        p_valid = 1'b1; p_chk = chk; p_x = W'(x); p_y = W'(y); p_exp = cur;
    endtask

    task automatic probes(input int n);
        int offs[7] = '{-17, -16, -15, 0, 15, 16, 17};
        int x, y;
        for (int i = 0; i < n; i++) begin
            x_position = W'($urandom_range(1, 2047));
            y_position = W'($urandom_range(1, 2047));
            if ($urandom_range(0, 3) != 0) begin
                x = m_dx + (($urandom_range(0, 1) == 1) ? offs[$urandom_range(0, 6)] : $urandom_range(0, 40) - 20);
                y = m_dy + (($urandom_range(0, 1) == 1) ? offs[$urandom_range(0, 6)] : $urandom_range(0, 40) - 20);
            end else begin
                x = $urandom_range(0, 639);
                y = $urandom_range(0, 479);
            end
            if (x < 0) x = 0;
            if (y < 0) y = 0;
            if (x == 640 && y == 480) x = 639;
            drive(x, y, 1'b1);
        end
    endtask

    task automatic end_frame(input int px, input int py);
        x_position = W'(px); y_position = W'(py);
        drive(640, 480, 1'b1);
        check("mv_eof", 32'(marker_valid), 32'(m_state != 0));
        drive(0, 0, 1'b1);
        if (m_en) m_frame_end(px, py);
        else begin m_clear(); m_upd = 1'b0; end
        check("mv_after", 32'(marker_valid), 32'(m_state != 0));
        x_position = W'($urandom); y_position = W'($urandom);
        drive(1, 0, 1'b0);
        if (m_upd) begin m_dx = m_cx; m_dy = m_cy; end
    endtask

    task automatic reset_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            vga_x = W'($urandom); vga_y = W'($urandom); pixel_in = PW'($urandom);
            @(posedge clk); #1;
            check("rst_pix", 32'(pixel_out), 32'h0);
            check("rst_xy", 32'({vga_x_out, vga_y_out}), 32'h0);
            check("rst_mv", 32'(marker_valid), 32'h0);
        end
        p_valid = 1'b0;
    endtask

    initial begin
        aresetn = 1'b0; enable = 1'b1;
        vga_x = '0; vga_y = '0; pixel_in = '0; x_position = '0; y_position = '0;
        reset_cycles(4);
        aresetn = 1'b1;

        // no detection: stay idle
        probes(10); end_frame(0, 0);
        // acquire (100,200), then directed edge pixels
        probes(10); end_frame(100, 200);
        drive(84, 200, 1'b1); drive(116, 190, 1'b1); drive(100, 184, 1'b1);
        drive(100, 200, 1'b1); drive(83, 200, 1'b1);
        probes(15); end_frame(200, 200);
        // smoothed left edge at 109
        drive(109, 200, 1'b1); drive(108, 200, 1'b1); drive(141, 216, 1'b1);
        probes(15); end_frame(0, 0);
        probes(10); end_frame(0, 0);
        probes(10); end_frame(0, 0);
        // re-acquire from hold with miss_cnt=3
        probes(10); end_frame(300, 100);
        probes(15);
        // loss: 7 misses hold, 8th drops to idle
        for (int f = 0; f < HF; f++) begin
            end_frame(0, 0);
            probes(12);
        end
        // randomized frames
        for (int f = 0; f < 12; f++) begin
            if ($urandom_range(0, 9) < 3) end_frame(0, 0);
            else end_frame($urandom_range(1, 639), $urandom_range(1, 479));
            probes(16);
        end

        // enable drop mid-frame
        end_frame(0, 0); end_frame(0, 0); end_frame(0, 0);
        end_frame(0, 0); end_frame(0, 0); end_frame(0, 0);
        end_frame(0, 0); end_frame(0, 0);
        end_frame(330, 240);
        probes(8);
        enable = 1'b0; m_en = 1'b0; m_clear();
        drive(320, 240, 1'b0);
        check("mv_en_drop", 32'(marker_valid), 32'h0);
        drive(346, 240, 1'b1); drive(314, 240, 1'b1); drive(330, 224, 1'b1);
        probes(8);
        end_frame(330, 240);
        enable = 1'b1; m_en = 1'b1;
        probes(6); end_frame(0, 0);
        probes(8);

        // async reset mid-frame
        end_frame(50, 60);
        probes(8);
        #2 aresetn = 1'b0;
        #1;
        check("rst_mid_pix", 32'(pixel_out), 32'h0);
        check("rst_mid_mv", 32'(marker_valid), 32'h0);
        m_clear(); m_dx = 0; m_dy = 0;
        reset_cycles(2);
        aresetn = 1'b1;
        probes(6); end_frame(50, 60);
        probes(12); end_frame(0, 0);
        probes(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
